// File: rtl/inst_line_responder_pkg.sv
// Shared constants and state encoding for the instruction line responder.
// Imported by the top level and by the line word packer.
package inst_line_responder_pkg;

  localparam int LINE_WORDS = 8;
  localparam int WORD_BITS  = 32;
  localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;
  localparam int SLOT_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_DRAIN,
    ST_RESP
  } state_t;

endpackage

// File: rtl/line_word_packer.sv
// Line assembly buffer: writes one 32-bit word into the selected slot of a 256-bit register.
// The whole buffer is cleared on reset.
module line_word_packer
  import inst_line_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic [SLOT_W-1:0]    slot,
  input  logic [WORD_BITS-1:0] word,
  output logic [LINE_BITS-1:0] line
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (wr) begin
      line[slot*WORD_BITS +: WORD_BITS] <= word;
    end
  end

endmodule

// File: rtl/inst_line_responder.sv
// Memory-side responder on the instruction read bus: fetches 8 consecutive words from a
// 1-cycle-latency word memory and returns them as one 256-bit line with a dev_rvalid pulse.
module inst_line_responder
  import inst_line_responder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int EXTRA_LAT = 0
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic [3:0]           cpu_ren,
  input  logic [31:0]          cpu_raddr,
  output logic                 dev_rrdy,
  output logic                 dev_rvalid,
  output logic [LINE_BITS-1:0] dev_rdata,
  output logic                 mem_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [WORD_BITS-1:0] mem_rdata
);

  localparam int BASE_W = ADDR_W - SLOT_W;

  state_t               state;
  state_t               next_state;
  logic [BASE_W-1:0]    base;
  logic [SLOT_W-1:0]    word_cnt;
  logic [3:0]           wait_cnt;
  logic                 accept;
  logic                 pack_wr;
  logic [SLOT_W-1:0]    pack_slot;
  logic [LINE_BITS-1:0] line;
  logic                 unused_bits;

  assign accept = (state == ST_IDLE) && (cpu_ren != 4'd0);

  // Address bits outside the line index are intentionally dropped, so larger addresses alias.
  assign unused_bits = ^{cpu_raddr[31:ADDR_W+2], cpu_raddr[4:0], line[LINE_BITS-1:LINE_BITS-WORD_BITS]};

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = (EXTRA_LAT > 0) ? ST_WAIT : ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'(EXTRA_LAT - 1)) begin
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (word_cnt == SLOT_W'(LINE_WORDS - 1)) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      base     <= '0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        base <= cpu_raddr[ADDR_W+1:5];
      end
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      word_cnt <= (state == ST_FETCH) ? word_cnt + SLOT_W'(1) : '0;
    end
  end

  // Read data lags the address by one cycle, so each capture targets the previous slot;
  // in DRAIN word_cnt has wrapped to 0, which makes the slot 7.
  assign pack_wr   = ((state == ST_FETCH) && (word_cnt != '0)) || (state == ST_DRAIN);
  assign pack_slot = word_cnt - SLOT_W'(1);

  line_word_packer u_packer (
    .clk   (cpu_clk),
    .rst_n (cpu_rst_n),
    .wr    (pack_wr),
    .slot  (pack_slot),
    .word  (mem_rdata),
    .line  (line)
  );

  // Word 7 arrives during DRAIN, so it is merged directly; dev_rdata never shows a partial line.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dev_rdata <= '0;
    end else if (state == ST_DRAIN) begin
      dev_rdata <= {mem_rdata, line[LINE_BITS-WORD_BITS-1:0]};
    end
  end

  assign dev_rrdy   = (state == ST_IDLE);
  assign dev_rvalid = (state == ST_RESP);
  assign mem_en     = (state == ST_FETCH);
  assign mem_addr   = {base, word_cnt};

endmodule

// File: tb/tb_inst_line_responder.sv
// Scoreboard bench for inst_line_responder: two instances (EXTRA_LAT 0 and 3) share one memory;
// accepted requests push expected lines and timing, a negedge monitor compares every cycle.
module tb_inst_line_responder;

  localparam int ADDR_W = 10;
  localparam int LAT0   = 0;
  localparam int LAT1   = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          ren       [2];
  logic [31:0]         raddr     [2];
  logic                rrdy      [2];
  logic                rvalid    [2];
  logic [255:0]        rdata     [2];
  logic                mem_en    [2];
  logic [ADDR_W-1:0]   mem_addr  [2];
  logic [31:0]         mem_rdata [2];
  logic [31:0]         mem       [1024];

  typedef struct {
    logic [255:0] line;
    int           acc;
    int           base_word;
  } exp_t;

  exp_t         q0 [$];
  exp_t         q1 [$];
  int           busy_until [2] = '{-1, -1};
  logic [255:0] last_line  [2] = '{256'd0, 256'd0};
  int           lat        [2] = '{LAT0, LAT1};
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  inst_line_responder #(.ADDR_W(ADDR_W), .EXTRA_LAT(LAT0)) dut0 (
    .cpu_clk    (clk),
    .cpu_rst_n  (rst_n),
    .cpu_ren    (ren[0]),
    .cpu_raddr  (raddr[0]),
    .dev_rrdy   (rrdy[0]),
    .dev_rvalid (rvalid[0]),
    .dev_rdata  (rdata[0]),
    .mem_en     (mem_en[0]),
    .mem_addr   (mem_addr[0]),
    .mem_rdata  (mem_rdata[0])
  );

  inst_line_responder #(.ADDR_W(ADDR_W), .EXTRA_LAT(LAT1)) dut3 (
    .cpu_clk    (clk),
    .cpu_rst_n  (rst_n),
    .cpu_ren    (ren[1]),
    .cpu_raddr  (raddr[1]),
    .dev_rrdy   (rrdy[1]),
    .dev_rvalid (rvalid[1]),
    .dev_rdata  (rdata[1]),
    .mem_en     (mem_en[1]),
    .mem_addr   (mem_addr[1]),
    .mem_rdata  (mem_rdata[1])
  );

  // Synchronous word memory with one cycle of read latency, one read port per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) mem_rdata[k] <= mem[mem_addr[k]];
    end
  end

  task automatic check_output(input string name, input int k, input logic [255:0] act,
                              input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [255:0] model_line(input int base_word);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = mem[base_word + i];
    return l;
  endfunction

  // Reference model: a request is taken only when the responder has finished the previous
  // line; the line base is the 32-byte line number modulo the 128 lines of memory.
  task automatic model_accept(input int k, input logic [3:0] r, input logic [31:0] a);
    exp_t e;
    if (r != 4'd0 && cyc > busy_until[k]) begin
      e.base_word = int'(((a >> 5) % 128) * 8);
      e.line      = model_line(e.base_word);
      e.acc       = cyc;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      busy_until[k] = cyc + lat[k] + 10;
    end
  endtask

  // Called just after a negedge; presents the request for one cycle.
  task automatic apply_stimulus(input logic [3:0] r0, input logic [31:0] a0,
                                input logic [3:0] r1, input logic [31:0] a1);
    ren[0] = r0; raddr[0] = a0;
    ren[1] = r1; raddr[1] = a1;
    model_accept(0, r0, a0);
    model_accept(1, r1, a1);
    @(posedge clk);
    #1;
    ren[0] = 4'd0;
    ren[1] = 4'd0;
    @(negedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_output("rst_rrdy", k, 256'(rrdy[k]), 256'd1);
      check_output("rst_rvalid", k, 256'(rvalid[k]), 256'd0);
      check_output("rst_mem_en", k, 256'(mem_en[k]), 256'd0);
      busy_until[k] = -1;
      last_line[k]  = '0;
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   have;
    int   fs;
    bit   exp_en;
    bit   exp_rv;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (k == 0) ? q0[0] : q1[0];
        fs     = e.acc + lat[k] + 1;
        exp_en = have && cyc >= fs && cyc <= fs + 7;
        exp_rv = have && cyc == e.acc + lat[k] + 10;
        check_output("mem_en", k, 256'(mem_en[k]), 256'(exp_en));
        if (exp_en && mem_en[k])
          check_output("mem_addr", k, 256'(mem_addr[k]), 256'(e.base_word + cyc - fs));
        check_output("rvalid", k, 256'(rvalid[k]), 256'(exp_rv));
        if (exp_rv) begin
          last_line[k] = e.line;
          if (k == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
        check_output("rdata", k, rdata[k], last_line[k]);
        check_output("rrdy", k, 256'(rrdy[k]), 256'(cyc > busy_until[k]));
      end
    end
  end

  initial begin
    int a;
    for (int w = 0; w < 1024; w++) mem[w] = 32'h1000_0000 + w;
    ren[0] = 4'd0; raddr[0] = '0;
    ren[1] = 4'd0; raddr[1] = '0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_output("init_rrdy", k, 256'(rrdy[k]), 256'd1);
      check_output("init_rvalid", k, 256'(rvalid[k]), 256'd0);
      check_output("init_mem_en", k, 256'(mem_en[k]), 256'd0);
      check_output("init_mem_addr", k, 256'(mem_addr[k]), 256'd0);
      check_output("init_rdata", k, rdata[k], 256'd0);
    end
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] basic line, busy request, back-to-back");
    a = cyc;
    apply_stimulus(4'hF, 32'h0000_0044, 4'h0, 32'h0);
    go_to(a + 3);
    apply_stimulus(4'hF, 32'h0000_0080, 4'h0, 32'h0);
    go_to(a + 11);
    apply_stimulus(4'hF, 32'h0000_0044, 4'h0, 32'h0);
    go_to(a + 25);

    $display("[TB] alias on dut0, extra latency with partial enable on dut3");
    a = cyc;
    apply_stimulus(4'hF, 32'h0000_1004, 4'h1, 32'h0000_0FFC);
    go_to(a + 16);

    $display("[TB] reset during fetch");
    a = cyc;
    apply_stimulus(4'h2, 32'h0000_0200, 4'h8, 32'h0000_0340);
    go_to(a + 4);
    mid_reset();
    go_to(cyc + 16);

    $display("[TB] randomized requests");
    for (int w = 0; w < 1024; w++) mem[w] = $urandom;
    for (int n = 0; n < 600; n++) begin
      apply_stimulus(($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom,
                     ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom);
    end
    go_to(cyc + 20);
    check_output("drain", 0, 256'(q0.size()), 256'd0);
    check_output("drain", 1, 256'(q1.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
